// File: rtl/lcd_byte_writer.sv
// Byte-wide command/data writer for a 4-bit HD44780-style LCD bus.
// Each byte is sent as two nibbles (high first), with setup, E-pulse and settle timing.
module lcd_byte_writer #(
  parameter int E_PULSE_CYCLES    = 12,
  parameter int SETUP_CYCLES      = 2,
  parameter int NIBBLE_GAP_CYCLES = 50,
  parameter int BYTE_GAP_CYCLES   = 2000,
  parameter int CLEAR_GAP_CYCLES  = 82000,
  parameter int CNT_W             = 20
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       iInitDone,
  input  logic       iValid,
  input  logic       iRS,
  input  logic [7:0] iData,
  output logic       oReady,
  output logic       oBusy,
  output logic       oLCD_Enabled,
  output logic       oLCD_RegisterSelect,
  output logic       oLCD_ReadWrite,
  output logic       oLCD_StrataFlashControl,
  output logic [3:0] oLCD_Data
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP_HI,
    S_PULSE_HI,
    S_GAP_NIB,
    S_SETUP_LO,
    S_PULSE_LO,
    S_GAP_BYTE
  } state_e;

  // Each state dwells N cycles: the counter starts at 0 on entry and the state exits at N-1.
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(E_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] NIB_LAST   =
    CNT_W'((NIBBLE_GAP_CYCLES > 0) ? NIBBLE_GAP_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] BYTE_LAST  = CNT_W'(BYTE_GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CLEAR_LAST = CNT_W'(CLEAR_GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       byte_q, byte_d;
  logic             rs_q, rs_d;
  logic             clear_q, clear_d;
  logic             e_q, e_d;
  logic             lcd_rs_q, lcd_rs_d;
  logic [3:0]       data_q, data_d;
  logic [CNT_W-1:0] gap_last;
  logic             accept;

  assign oReady   = (state_q == S_IDLE) && iInitDone;
  assign accept   = oReady && iValid;
  assign gap_last = clear_q ? CLEAR_LAST : BYTE_LAST;

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_ONE;
    byte_d  = byte_q;
    rs_d    = rs_q;
    clear_d = clear_q;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (accept) begin
          state_d = S_SETUP_HI;
          byte_d  = iData;
          rs_d    = iRS;
          clear_d = !iRS && ((iData == 8'h01) || (iData == 8'h02));
        end
      end
      S_SETUP_HI: if (cnt_q == SETUP_LAST) begin
        state_d = S_PULSE_HI;
        cnt_d   = '0;
      end
      S_PULSE_HI: if (cnt_q == PULSE_LAST) begin
        state_d = (NIBBLE_GAP_CYCLES == 0) ? S_SETUP_LO : S_GAP_NIB;
        cnt_d   = '0;
      end
      S_GAP_NIB: if (cnt_q == NIB_LAST) begin
        state_d = S_SETUP_LO;
        cnt_d   = '0;
      end
      S_SETUP_LO: if (cnt_q == SETUP_LAST) begin
        state_d = S_PULSE_LO;
        cnt_d   = '0;
      end
      S_PULSE_LO: if (cnt_q == PULSE_LAST) begin
        state_d = S_GAP_BYTE;
        cnt_d   = '0;
      end
      S_GAP_BYTE: if (cnt_q == gap_last) begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Pin values are decoded from the next state so the flops drive them glitch-free.
    e_d      = (state_d == S_PULSE_HI) || (state_d == S_PULSE_LO);
    lcd_rs_d = (state_d != S_IDLE) ? rs_d : 1'b0;
    case (state_d)
      S_IDLE:                           data_d = 4'h0;
      S_SETUP_HI, S_PULSE_HI, S_GAP_NIB: data_d = byte_d[7:4];
      default:                          data_d = byte_d[3:0];
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      byte_q   <= '0;
      rs_q     <= 1'b0;
      clear_q  <= 1'b0;
      e_q      <= 1'b0;
      lcd_rs_q <= 1'b0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      byte_q   <= byte_d;
      rs_q     <= rs_d;
      clear_q  <= clear_d;
      e_q      <= e_d;
      lcd_rs_q <= lcd_rs_d;
      data_q   <= data_d;
    end
  end

  assign oBusy                   = (state_q != S_IDLE);
  assign oLCD_Enabled            = e_q;
  assign oLCD_RegisterSelect     = lcd_rs_q;
  assign oLCD_Data               = data_q;
  assign oLCD_ReadWrite          = 1'b0;
  assign oLCD_StrataFlashControl = 1'b1;

endmodule

// File: tb/tb_lcd_byte_writer.sv
// Directed bench for lcd_byte_writer; gaps are shortened (BYTE 200, CLEAR 3000) to keep runs short.
// A second instance with a zero nibble gap exercises that corner.
module tb_lcd_byte_writer;

  // Hand-computed: byte = 2+12+50+2+12+200 = 278, clear = 78+3000 = 3078, zero-gap byte = 2+12+2+12+200 = 228.
  localparam int BYTE_T  = 278;
  localparam int CLEAR_T = 3078;
  localparam int NG_T    = 228;

  typedef struct packed {
    int r1;
    int f1;
    int r2;
    int f2;
    int done;
  } tim_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       init_done;
  logic       valid;
  logic       rs;
  logic [7:0] data;

  logic       ready_a, busy_a, e_a, rsel_a, rw_a, sf_a;
  logic [3:0] d_a;
  logic       ready_b, busy_b, e_b, rsel_b, rw_b, sf_b;
  logic [3:0] d_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  lcd_byte_writer #(
    .E_PULSE_CYCLES(12), .SETUP_CYCLES(2), .NIBBLE_GAP_CYCLES(50),
    .BYTE_GAP_CYCLES(200), .CLEAR_GAP_CYCLES(3000), .CNT_W(20)
  ) dut_a (
    .Clock(clk), .Reset(rst), .iInitDone(init_done), .iValid(valid), .iRS(rs), .iData(data),
    .oReady(ready_a), .oBusy(busy_a), .oLCD_Enabled(e_a), .oLCD_RegisterSelect(rsel_a),
    .oLCD_ReadWrite(rw_a), .oLCD_StrataFlashControl(sf_a), .oLCD_Data(d_a)
  );

  lcd_byte_writer #(
    .E_PULSE_CYCLES(12), .SETUP_CYCLES(2), .NIBBLE_GAP_CYCLES(0),
    .BYTE_GAP_CYCLES(200), .CLEAR_GAP_CYCLES(3000), .CNT_W(20)
  ) dut_b (
    .Clock(clk), .Reset(rst), .iInitDone(init_done), .iValid(valid), .iRS(rs), .iData(data),
    .oReady(ready_b), .oBusy(busy_b), .oLCD_Enabled(e_b), .oLCD_RegisterSelect(rsel_b),
    .oLCD_ReadWrite(rw_b), .oLCD_StrataFlashControl(sf_b), .oLCD_Data(d_b)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits for dut_a to be ready, presents one byte for exactly one accept edge, then scrambles the inputs.
  task automatic accept_byte(input logic r, input logic [7:0] b);
    bit ok = 1'b0;
    for (int n = 0; n < 5000 && !ok; n++) begin
      if (ready_a) ok = 1'b1;
      else step();
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL accept_wait ready=%0b expected 1", ready_a);
    end
    rs = r; data = b; valid = 1'b1;
    step();
    valid = 1'b0; data = ~b; rs = ~r;
  endtask

  // Follows one transfer cycle by cycle from the accept edge until oBusy drops.
  task automatic watch(input bit sel, input logic rs_exp, input logic [7:0] b,
                       output tim_t t, output int derr, output int rerr);
    logic       e, e_prev, bz, r;
    logic [3:0] d;
    t = '{r1: -1, f1: -1, r2: -1, f2: -1, done: -1};
    derr = 0; rerr = 0; e_prev = 1'b0;
    for (int k = 0; k < 4000; k++) begin
      e  = sel ? e_b : e_a;
      d  = sel ? d_b : d_a;
      bz = sel ? busy_b : busy_a;
      r  = sel ? rsel_b : rsel_a;
      if (!bz) begin
        t.done = k;
        break;
      end
      if (k == 0 && d !== b[7:4]) derr++;
      if (e && !e_prev) begin
        if (t.r1 < 0) t.r1 = k;
        else if (t.r2 < 0) t.r2 = k;
        else derr++;
      end
      if (!e && e_prev) begin
        if (t.f1 < 0) begin
          t.f1 = k;
          if (d !== (sel ? b[3:0] : b[7:4])) derr++;
        end else begin
          t.f2 = k;
          if (d !== b[3:0]) derr++;
        end
      end
      if (e && d !== ((t.r2 < 0) ? b[7:4] : b[3:0])) derr++;
      if (r !== rs_exp) rerr++;
      e_prev = e;
      step();
    end
  endtask

  task automatic test_reset();
    int e_seen = 0, rdy_seen = 0;
    rst = 1'b1; init_done = 1'b0; valid = 1'b1; rs = 1'b0; data = 8'h28;
    #3;
    checks++; if ({e_a, d_a, rsel_a, busy_a} !== 7'b0) begin errors++;
      $display("FAIL reset_pins got E=%0b D=%0h RS=%0b busy=%0b expected all 0", e_a, d_a, rsel_a, busy_a); end
    checks++; if (ready_a !== 1'b0) begin errors++;
      $display("FAIL reset_ready got %0b expected 0", ready_a); end
    checks++; if ({rw_a, sf_a} !== 2'b01) begin errors++;
      $display("FAIL tie_offs got RW=%0b SF=%0b expected RW=0 SF=1", rw_a, sf_a); end
    @(negedge clk); rst = 1'b0;
    for (int k = 0; k < 10000; k++) begin
      step();
      if (e_a || e_b || busy_a) e_seen++;
      if (ready_a) rdy_seen++;
    end
    checks++; if (e_seen !== 0) begin errors++;
      $display("FAIL no_init_activity got %0d active cycles expected 0", e_seen); end
    checks++; if (rdy_seen !== 0) begin errors++;
      $display("FAIL no_init_ready got %0d ready cycles expected 0", rdy_seen); end
    valid = 1'b0;
  endtask

  task automatic test_nibble_gap_zero();
    tim_t t, x;
    int   de, re;
    init_done = 1'b1;
    accept_byte(1'b0, 8'h6C);
    watch(1'b1, 1'b0, 8'h6C, t, de, re);
    x = '{r1: 2, f1: 14, r2: 16, f2: 28, done: NG_T};
    checks++; if (t !== x) begin errors++;
      $display("FAIL ng0_timing got %0d/%0d/%0d/%0d/%0d expected 2/14/16/28/%0d", t.r1, t.f1, t.r2, t.f2, t.done, NG_T); end
    checks++; if (de + re !== 0) begin errors++;
      $display("FAIL ng0_pins got data_err=%0d rs_err=%0d expected 0", de, re); end
  endtask

  task automatic test_cmd_28();
    tim_t t, x;
    int   de, re;
    accept_byte(1'b0, 8'h28);
    watch(1'b0, 1'b0, 8'h28, t, de, re);
    x = '{r1: 2, f1: 14, r2: 66, f2: 78, done: BYTE_T};
    checks++; if (t !== x) begin errors++;
      $display("FAIL cmd28_timing got %0d/%0d/%0d/%0d/%0d expected 2/14/66/78/%0d", t.r1, t.f1, t.r2, t.f2, t.done, BYTE_T); end
    checks++; if (de !== 0) begin errors++; $display("FAIL cmd28_data got %0d bad cycles expected 0", de); end
    checks++; if (re !== 0) begin errors++; $display("FAIL cmd28_rs got %0d bad cycles expected 0", re); end
    checks++; if ({ready_a, d_a, rsel_a} !== 6'b1_0000_0) begin errors++;
      $display("FAIL idle_pins got ready=%0b D=%0h RS=%0b expected 1/0/0", ready_a, d_a, rsel_a); end
  endtask

  // A different byte is held on the inputs while busy; it must neither be taken nor disturb the transfer.
  task automatic test_data_busy_ignore();
    tim_t t, x;
    int   de, re;
    accept_byte(1'b1, 8'h41);
    valid = 1'b1; data = 8'h99; rs = 1'b0;
    watch(1'b0, 1'b1, 8'h41, t, de, re);
    valid = 1'b0;
    x = '{r1: 2, f1: 14, r2: 66, f2: 78, done: BYTE_T};
    checks++; if (t !== x) begin errors++;
      $display("FAIL data41_timing got %0d/%0d/%0d/%0d/%0d expected 2/14/66/78/%0d", t.r1, t.f1, t.r2, t.f2, t.done, BYTE_T); end
    checks++; if (de !== 0) begin errors++; $display("FAIL data41_data got %0d bad cycles expected 0", de); end
    checks++; if (re !== 0) begin errors++; $display("FAIL data41_rs got %0d bad cycles expected 0", re); end
  endtask

  task automatic test_clear();
    logic [8:0] tbl[4]   = '{9'h001, 9'h002, 9'h003, 9'h101};
    int         tdone[4] = '{CLEAR_T, CLEAR_T, BYTE_T, BYTE_T};
    tim_t t;
    int   de, re;
    for (int i = 0; i < 4; i++) begin
      accept_byte(tbl[i][8], tbl[i][7:0]);
      watch(1'b0, tbl[i][8], tbl[i][7:0], t, de, re);
      checks++; if (t.done !== tdone[i] || t.f2 !== 78) begin errors++;
        $display("FAIL clear_wait[%0d] got done=%0d f2=%0d expected done=%0d f2=78", i, t.done, t.f2, tdone[i]); end
      checks++; if (de + re !== 0) begin errors++;
        $display("FAIL clear_pins[%0d] got data_err=%0d rs_err=%0d expected 0", i, de, re); end
    end
  endtask

  task automatic test_init_drop();
    tim_t t;
    int   de, re, busy_seen = 0;
    accept_byte(1'b1, 8'hC5);
    init_done = 1'b0; valid = 1'b1; data = 8'h11;
    watch(1'b0, 1'b1, 8'hC5, t, de, re);
    checks++; if (t.done !== BYTE_T || de !== 0) begin errors++;
      $display("FAIL init_drop_transfer got done=%0d data_err=%0d expected %0d/0", t.done, de, BYTE_T); end
    checks++; if (ready_a !== 1'b0) begin errors++;
      $display("FAIL init_drop_ready got %0b expected 0", ready_a); end
    for (int k = 0; k < 20; k++) begin
      step();
      if (busy_a) busy_seen++;
    end
    checks++; if (busy_seen !== 0) begin errors++;
      $display("FAIL init_drop_accept got %0d busy cycles expected 0", busy_seen); end
    valid = 1'b0; init_done = 1'b1;
  endtask

  task automatic test_back_to_back();
    logic [8:0] src[3] = '{9'h030, 9'h15A, 9'h0C3};
    int         acc[3] = '{0, 0, 0};
    logic [3:0] nib[8];
    logic       rsn[8];
    logic [3:0] en;
    int         idx = 0, nrise = 0, cyc = 0, bad = 0;
    logic       hs, e_prev;
    bit         ok = 1'b0;
    for (int n = 0; n < 5000 && !ready_a; n++) step();
    rs = src[0][8]; data = src[0][7:0]; valid = 1'b1;
    for (int k = 0; k < 1500 && !ok; k++) begin
      hs = valid && ready_a;
      e_prev = e_a;
      step();
      cyc++;
      if (e_a && !e_prev && nrise < 8) begin
        nib[nrise] = d_a; rsn[nrise] = rsel_a; nrise++;
      end
      if (hs) begin
        acc[idx] = cyc; idx++;
        if (idx < 3) begin rs = src[idx][8]; data = src[idx][7:0]; end
        else valid = 1'b0;
      end
      if (idx == 3 && !busy_a) ok = 1'b1;
    end
    valid = 1'b0;
    checks++; if (idx !== 3 || !ok) begin errors++;
      $display("FAIL b2b_count got %0d accepts done=%0b expected 3/1", idx, ok); end
    // One IDLE cycle after each transfer carries the next handshake.
    checks++; if (acc[1] - acc[0] !== BYTE_T + 1 || acc[2] - acc[1] !== BYTE_T + 1) begin errors++;
      $display("FAIL b2b_spacing got %0d,%0d expected %0d", acc[1] - acc[0], acc[2] - acc[1], BYTE_T + 1); end
    checks++; if (nrise !== 6) begin errors++;
      $display("FAIL b2b_pulses got %0d expected 6", nrise); end
    for (int j = 0; j < 6 && j < nrise; j++) begin
      en = (j % 2 == 0) ? src[j / 2][7:4] : src[j / 2][3:0];
      if (nib[j] !== en || rsn[j] !== src[j / 2][8]) bad++;
    end
    checks++; if (bad !== 0) begin errors++;
      $display("FAIL b2b_nibbles got %0d wrong nibbles expected 0", bad); end
  endtask

  task automatic test_reset_mid();
    tim_t t, x;
    int   de, re;
    accept_byte(1'b0, 8'h9E);
    for (int k = 0; k < 70; k++) step();
    checks++; if ({e_a, d_a} !== 5'b1_1110) begin errors++;
      $display("FAIL mid_pulse_lo got E=%0b D=%0h expected 1/e", e_a, d_a); end
    rst = 1'b1;
    #1;
    checks++; if ({e_a, busy_a, d_a} !== 6'b0) begin errors++;
      $display("FAIL async_reset got E=%0b busy=%0b D=%0h expected 0/0/0", e_a, busy_a, d_a); end
    @(negedge clk); rst = 1'b0;
    step();
    checks++; if ({busy_a, ready_a} !== 2'b01) begin errors++;
      $display("FAIL post_reset_idle got busy=%0b ready=%0b expected 0/1", busy_a, ready_a); end
    accept_byte(1'b1, 8'hA7);
    watch(1'b0, 1'b1, 8'hA7, t, de, re);
    x = '{r1: 2, f1: 14, r2: 66, f2: 78, done: BYTE_T};
    checks++; if (t !== x || de + re !== 0) begin errors++;
      $display("FAIL post_reset_byte got %0d/%0d/%0d/%0d/%0d errs=%0d expected 2/14/66/78/%0d errs=0",
               t.r1, t.f1, t.r2, t.f2, t.done, de + re, BYTE_T); end
  endtask

  initial begin
    test_reset();
    test_nibble_gap_zero();
    test_cmd_28();
    test_data_busy_ignore();
    test_clear();
    test_init_drop();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
